// File: rtl/wave_seq_gen.sv
// wave_seq_gen: registered waveform generator with a programmable prescaler.
// Shapes: 00 square, 01 sawtooth, 10 triangle, 11 constant midscale.
// Optional build macro WAVE_GEN_WRAP_FLAG_EN adds the registered 'wrap'
// period-start pulse. Without it the port and its logic are absent.
module wave_seq_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       pattern,
  input  logic [DIV_W-1:0] div,
`ifdef WAVE_GEN_WRAP_FLAG_EN
  output logic             wrap,
`endif
  output logic [WIDTH-1:0] wave
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] pre_cnt, pre_cnt_d;
  logic [WIDTH-1:0] phase, phase_d, phase_inc;
  logic [WIDTH-1:0] wave_d;
  logic [1:0]       pat_q, pat_d;
  dir_e             dir, dir_d;
  logic             restart, step;

  assign restart   = en && (pattern != pat_q);
  assign step      = en && !restart && (pre_cnt >= div);
  assign phase_inc = phase + ONE;

  // State register: reset, otherwise take the computed next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      phase   <= '0;
      dir     <= UP;
      pat_q   <= 2'b00;
      wave    <= '0;
    end else begin
      pre_cnt <= pre_cnt_d;
      phase   <= phase_d;
      dir     <= dir_d;
      pat_q   <= pat_d;
      wave    <= wave_d;
    end
  end

  // Next-state: hold when disabled, restart on pattern change, else step or count.
  always_comb begin
    pre_cnt_d = pre_cnt;
    phase_d   = phase;
    dir_d     = dir;
    pat_d     = pat_q;
    wave_d    = wave;
    if (restart) begin
      pat_d     = pattern;
      pre_cnt_d = '0;
      phase_d   = '0;
      dir_d     = UP;
      wave_d    = (pattern == 2'b11) ? MID : '0;
    end else if (step) begin
      pre_cnt_d = '0;
      unique case (pat_q)
        2'b00: begin
          phase_d = phase_inc;
          wave_d  = phase_inc[WIDTH-1] ? MAX : '0;
        end
        2'b01: begin
          phase_d = phase_inc;
          wave_d  = phase_inc;
        end
        2'b10: begin
          // Turn without repeating the peak sample.
          if (dir == UP) begin
            if (wave == MAX) begin
              dir_d  = DOWN;
              wave_d = MAX - ONE;
            end else begin
              wave_d = wave + ONE;
            end
          end else begin
            if (wave == '0) begin
              dir_d  = UP;
              wave_d = ONE;
            end else begin
              wave_d = wave - ONE;
            end
          end
        end
        default: begin
          // Constant level; phase still runs so the period marker keeps ticking.
          phase_d = phase_inc;
          wave_d  = MID;
        end
      endcase
    end else if (en) begin
      pre_cnt_d = pre_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef WAVE_GEN_WRAP_FLAG_EN
  logic wrap_ev;

  // Period start: phase rolls over, or the triangle turns at the bottom.
  always_comb begin
    wrap_ev = 1'b0;
    if (step) begin
      if (pat_q == 2'b10) wrap_ev = (dir == DOWN) && (wave == '0);
      else                wrap_ev = (phase == MAX);
    end
  end

  // Registered one-cycle pulse, cleared by reset, restart and en=0.
  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= wrap_ev;
  end
`endif

endmodule

// File: tb/tb_wave_seq_gen.sv
// tb_wave_seq_gen: directed table, corner-case sequences and a randomized run
// against a step-count based reference model of wave_seq_gen (WIDTH=8, DIV_W=8).
module tb_wave_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] pattern = 2'b01;
  logic [7:0] div = 8'd0;
  logic [7:0] wave;
`ifdef WAVE_GEN_WRAP_FLAG_EN
  logic       wrap;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: restart pattern, steps taken since restart, prescaler count.
  int  m_pat = 0;
  int  m_k   = 0;
  int  m_cnt = 0;
  bit  m_wrap = 1'b0;

  wave_seq_gen #(.WIDTH(8), .DIV_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .pattern(pattern),
    .div(div),
`ifdef WAVE_GEN_WRAP_FLAG_EN
    .wrap(wrap),
`endif
    .wave(wave)
  );

  always #5 clk = ~clk;

  function automatic int exp_wave(int p, int k);
    int m;
    case (p)
      0: return ((k % 256) >= 128) ? 255 : 0;
      1: return k % 256;
      2: begin
        m = k % 510;
        return (m <= 255) ? m : 510 - m;
      end
      default: return 128;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the applied inputs, optionally compare.
  task automatic tick(input bit cmp);
    @(posedge clk);
    #1;
    if (rst) begin
      m_pat = 0; m_k = 0; m_cnt = 0; m_wrap = 1'b0;
    end else if (!en) begin
      m_wrap = 1'b0;
    end else if (int'(pattern) != m_pat) begin
      m_pat = int'(pattern); m_k = 0; m_cnt = 0; m_wrap = 1'b0;
    end else if (m_cnt >= int'(div)) begin
      m_cnt = 0;
      m_k++;
      if (m_pat == 2) m_wrap = (m_k % 510 == 1) && (m_k > 1);
      else            m_wrap = (m_k % 256 == 0);
    end else begin
      m_cnt++;
      m_wrap = 1'b0;
    end
    if (cmp) begin
      chk("model_wave", int'(wave), exp_wave(m_pat, m_k));
`ifdef WAVE_GEN_WRAP_FLAG_EN
      chk("model_wrap", int'(wrap), int'(m_wrap));
`endif
    end
  endtask

  typedef struct {
    bit       rst;
    bit       en;
    bit [1:0] pat;
    bit [7:0] div;
    int       exp;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // Reset, saw start, prescaler lowered mid-count, hold, switch to const.
    vecs[0]  = '{1, 0, 2'b01, 8'd0, 0};
    vecs[1]  = '{1, 0, 2'b01, 8'd0, 0};
    vecs[2]  = '{0, 1, 2'b01, 8'd0, 0};   // restart
    vecs[3]  = '{0, 1, 2'b01, 8'd0, 1};
    vecs[4]  = '{0, 1, 2'b01, 8'd0, 2};
    vecs[5]  = '{0, 1, 2'b01, 8'd3, 2};
    vecs[6]  = '{0, 1, 2'b01, 8'd3, 2};
    vecs[7]  = '{0, 1, 2'b01, 8'd3, 2};
    vecs[8]  = '{0, 1, 2'b01, 8'd3, 3};
    vecs[9]  = '{0, 1, 2'b01, 8'd3, 3};
    vecs[10] = '{0, 1, 2'b01, 8'd3, 3};   // pre_cnt now 2
    vecs[11] = '{0, 1, 2'b01, 8'd1, 4};   // lowered div: immediate step
    vecs[12] = '{0, 1, 2'b01, 8'd1, 4};
    vecs[13] = '{0, 1, 2'b01, 8'd1, 5};
    vecs[14] = '{0, 0, 2'b01, 8'd0, 5};
    vecs[15] = '{0, 0, 2'b11, 8'd0, 5};   // pattern change ignored while frozen
    vecs[16] = '{0, 1, 2'b11, 8'd0, 128};
    vecs[17] = '{0, 1, 2'b11, 8'd0, 128};
    vecs[18] = '{1, 0, 2'b11, 8'd0, 0};
    vecs[19] = '{0, 1, 2'b00, 8'd0, 0};   // square from reset, no restart

    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; pattern = vecs[i].pat; div = vecs[i].div;
      tick(1'b1);
      chk($sformatf("vec%0d_wave", i), int'(wave), vecs[i].exp);
    end

    // Hold: saw at 37 frozen for 10 clocks.
    rst = 1'b1; tick(1'b0);
    rst = 1'b0; en = 1'b1; pattern = 2'b01; div = 8'd0;
    tick(1'b1);
    repeat (37) tick(1'b1);
    chk("saw_at_37", int'(wave), 37);
    en = 1'b0;
    repeat (10) tick(1'b1);
    chk("hold_37", int'(wave), 37);
    en = 1'b1; pattern = 2'b11;
    tick(1'b1);
    chk("const_restart", int'(wave), 128);
    repeat (5) tick(1'b1);
    chk("const_hold", int'(wave), 128);

    // Saw full wrap: 255 then 0 after 256 steps.
    pattern = 2'b01;
    tick(1'b1);
    chk("saw_restart", int'(wave), 0);
    repeat (255) tick(1'b1);
    chk("saw_max", int'(wave), 255);
    tick(1'b1);
    chk("saw_wrap", int'(wave), 0);
`ifdef WAVE_GEN_WRAP_FLAG_EN
    chk("saw_wrap_flag", int'(wrap), 1);
    tick(1'b1);
    chk("saw_wrap_clear", int'(wrap), 0);
    repeat (254) tick(1'b1);
    chk("saw_pre_wrap", int'(wave), 255);
    en = 1'b0;
    repeat (5) tick(1'b1);
    chk("frozen_no_wrap", int'(wrap), 0);
    en = 1'b1;
    tick(1'b1);
    chk("late_wrap_flag", int'(wrap), 1);
    chk("late_wrap_wave", int'(wave), 0);
`endif

    // Triangle: 0..255, 254..0, then 1.
    pattern = 2'b10;
    tick(1'b1);
    chk("tri_restart", int'(wave), 0);
    repeat (255) tick(1'b1);
    chk("tri_peak", int'(wave), 255);
    tick(1'b1);
    chk("tri_turn_down", int'(wave), 254);
    repeat (253) tick(1'b1);
    chk("tri_at_1", int'(wave), 1);
    tick(1'b1);
    chk("tri_floor", int'(wave), 0);
    tick(1'b1);
    chk("tri_turn_up", int'(wave), 1);
`ifdef WAVE_GEN_WRAP_FLAG_EN
    chk("tri_wrap_flag", int'(wrap), 1);
`endif

    // Square: 128 clocks low, 128 high.
    rst = 1'b1; tick(1'b1);
    rst = 1'b0; pattern = 2'b00;
    repeat (127) tick(1'b1);
    chk("sq_low_end", int'(wave), 0);
    tick(1'b1);
    chk("sq_high_start", int'(wave), 255);
    repeat (127) tick(1'b1);
    chk("sq_high_end", int'(wave), 255);
    tick(1'b1);
    chk("sq_low_again", int'(wave), 0);

    // Randomized run against the model.
    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 149) == 0) pattern = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0)  div = 8'($urandom_range(0, 5));
      tick(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
